// File: rtl/demux3_onehot_buf_pkg.sv
// Shared select encoding and legality check for the one-hot 3-way mux/demux pair.
// Keeping them here keeps the mux and this block decoding Sel the same way.
package demux3_onehot_buf_pkg;

  localparam int SEL_W = 3;
  localparam int NUM_CH = 3;

  localparam logic [SEL_W-1:0] SEL_CH1 = 3'b001;
  localparam logic [SEL_W-1:0] SEL_CH2 = 3'b010;
  localparam logic [SEL_W-1:0] SEL_CH3 = 3'b100;

  // True only for exactly one bit set; 000 and multi-hot patterns are illegal.
  function automatic logic onehot3(input logic [SEL_W-1:0] sel);
    return (sel == SEL_CH1) || (sel == SEL_CH2) || (sel == SEL_CH3);
  endfunction

endpackage

// File: rtl/demux3_onehot_buf_if.sv
// Source stream, three sink streams and the illegal-select status of the demux.
interface demux3_onehot_buf_if #(
  parameter int WIDTH     = 32,
  parameter int ERR_CNT_W = 8
);
  logic [WIDTH-1:0]     InputData;
  logic                 InputValid;
  logic                 InputReady;
  logic [2:0]           Sel;

  logic [WIDTH-1:0]     OutputData1;
  logic [WIDTH-1:0]     OutputData2;
  logic [WIDTH-1:0]     OutputData3;
  logic                 OutputValid1;
  logic                 OutputValid2;
  logic                 OutputValid3;
  logic                 OutputReady1;
  logic                 OutputReady2;
  logic                 OutputReady3;

  logic                 SelError;
  logic [ERR_CNT_W-1:0] ErrCount;

  modport master (
    output InputData, InputValid, Sel,
    output OutputReady1, OutputReady2, OutputReady3,
    input  InputReady,
    input  OutputData1, OutputData2, OutputData3,
    input  OutputValid1, OutputValid2, OutputValid3,
    input  SelError, ErrCount
  );

  modport slave (
    input  InputData, InputValid, Sel,
    input  OutputReady1, OutputReady2, OutputReady3,
    output InputReady,
    output OutputData1, OutputData2, OutputData3,
    output OutputValid1, OutputValid2, OutputValid3,
    output SelError, ErrCount
  );
endinterface

// File: rtl/demux3_onehot_buf_slot.sv
// One-entry registered output slot with valid/ready handshake and a load strobe.
module demux_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] loadData,
  input  logic             outReady,
  output logic [WIDTH-1:0] outData,
  output logic             outValid,
  output logic             canAccept
);

  // Empty, or draining this cycle: allows a full 1 word/cycle stream.
  assign canAccept = ~outValid | outReady;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data is reset as well as valid so the sink never sees X after reset.
      outValid <= 1'b0;
      outData  <= '0;
    end else if (load) begin
      outValid <= 1'b1;
      outData  <= loadData;
    end else if (outValid && outReady) begin
      outValid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux3_onehot_buf.sv
// One-hot 1:3 stream demux with per-sink registered slots; illegal selects are
// consumed, flagged with a one-cycle pulse and counted (saturating).
module demux3_onehot_buf
  import demux3_onehot_buf_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ERR_CNT_W = 8
) (
  input logic clk,
  input logic rst,
  demux3_onehot_buf_if.slave bus
);

  logic                 selLegal;
  logic [NUM_CH-1:0]    chReady;
  logic [NUM_CH-1:0]    canAccept;
  logic [NUM_CH-1:0]    load;
  logic [NUM_CH-1:0]    slotValid;
  logic [WIDTH-1:0]     slotData [NUM_CH];
  logic                 illegalAccept;
  logic                 selError;
  logic [ERR_CNT_W-1:0] errCount;

  assign selLegal = onehot3(bus.Sel);
  assign chReady  = {bus.OutputReady3, bus.OutputReady2, bus.OutputReady1};

  // With a legal Sel exactly one bit survives the AND; illegal words are always taken.
  assign bus.InputReady = selLegal ? |(bus.Sel & canAccept) : 1'b1;
  assign load           = {NUM_CH{bus.InputValid & selLegal}} & bus.Sel & canAccept;
  assign illegalAccept  = bus.InputValid & ~selLegal;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[k]),
      .loadData  (bus.InputData),
      .outReady  (chReady[k]),
      .outData   (slotData[k]),
      .outValid  (slotValid[k]),
      .canAccept (canAccept[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      selError <= 1'b0;
      errCount <= '0;
    end else begin
      selError <= illegalAccept;
      if (illegalAccept && (errCount != '1)) begin
        errCount <= errCount + 1'b1;
      end
    end
  end

  assign bus.OutputData1  = slotData[0];
  assign bus.OutputData2  = slotData[1];
  assign bus.OutputData3  = slotData[2];
  assign bus.OutputValid1 = slotValid[0];
  assign bus.OutputValid2 = slotValid[1];
  assign bus.OutputValid3 = slotValid[2];
  assign bus.SelError     = selError;
  assign bus.ErrCount     = errCount;

endmodule

// File: tb/tb_demux3_onehot_buf.sv
// Randomized and directed bench for demux3_onehot_buf against a behavioural model.
module tb_demux3_onehot_buf;

  localparam int WIDTH     = 32;
  localparam int ERR_CNT_W = 8;
  localparam int ERR_MAX   = (1 << ERR_CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;

  demux3_onehot_buf_if #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W)) ifc ();

  demux3_onehot_buf #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit          mValid [3];
  logic [31:0] mData  [3];
  int          mErr;
  bit          mSelErr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      mValid[k] = 1'b0;
      mData[k]  = '0;
    end
    mErr    = 0;
    mSelErr = 1'b0;
  endfunction

  // Channel number (0..2) addressed by a legal Sel, -1 if illegal.
  function automatic int sel_chan(input logic [2:0] s);
    if ($countones(s) != 1) return -1;
    for (int k = 0; k < 3; k++) if (s[k]) return k;
    return -1;
  endfunction

  // One clock cycle: drive, check current outputs against model, advance model.
  task automatic cycle(input logic r, input logic v, input logic [2:0] s,
                       input logic [31:0] d, input logic [2:0] rdy);
    int   ch;
    bit   expReady;
    logic gotValid [3];
    logic [31:0] gotData [3];

    rst              = r;
    ifc.InputValid   = v;
    ifc.Sel          = s;
    ifc.InputData    = d;
    ifc.OutputReady1 = rdy[0];
    ifc.OutputReady2 = rdy[1];
    ifc.OutputReady3 = rdy[2];
    #1;

    ch       = sel_chan(s);
    expReady = (ch < 0) ? 1'b1 : (!mValid[ch] || rdy[ch]);

    gotValid = '{ifc.OutputValid1, ifc.OutputValid2, ifc.OutputValid3};
    gotData  = '{ifc.OutputData1, ifc.OutputData2, ifc.OutputData3};

    check("in_ready", 64'(ifc.InputReady), 64'(expReady));
    for (int k = 0; k < 3; k++) begin
      check($sformatf("valid%0d", k + 1), 64'(gotValid[k]), 64'(mValid[k]));
      check($sformatf("data%0d", k + 1),  64'(gotData[k]),  64'(mData[k]));
    end
    check("sel_error", 64'(ifc.SelError), 64'(mSelErr));
    check("err_count", 64'(ifc.ErrCount), 64'(mErr));

    if (r) begin
      model_reset();
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (v && ch == k && expReady) begin
          mData[k]  = d;
          mValid[k] = 1'b1;
        end else if (mValid[k] && rdy[k]) begin
          mValid[k] = 1'b0;
        end
      end
      mSelErr = v && (ch < 0);
      if (mSelErr && mErr < ERR_MAX) mErr++;
    end

    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] illegalSel [5];
    illegalSel = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

    rst              = 1'b1;
    ifc.InputValid   = 1'b0;
    ifc.Sel          = 3'b000;
    ifc.InputData    = '0;
    ifc.OutputReady1 = 1'b0;
    ifc.OutputReady2 = 1'b0;
    ifc.OutputReady3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset mid-stream with slot 2 valid and a nonzero error count.
    cycle(0, 1, 3'b011, 32'h55, 3'b000);
    cycle(0, 1, 3'b010, 32'hCAFE_F00D, 3'b000);
    cycle(1, 1, 3'b001, 32'h1234_5678, 3'b000);
    cycle(0, 0, 3'b000, 32'h0, 3'b000);
    check("rst_err_zero", 64'(ifc.ErrCount), 64'd0);

    // Single route to channel 2.
    cycle(0, 1, 3'b010, 32'hDEAD_BEEF, 3'b111);
    cycle(0, 0, 3'b000, 32'h0, 3'b000);
    check("route_data2", 64'(ifc.OutputData2), 64'hDEAD_BEEF);
    cycle(0, 0, 3'b000, 32'h0, 3'b111);

    // Backpressure on channel 1.
    cycle(0, 1, 3'b001, 32'h11, 3'b000);
    cycle(0, 1, 3'b001, 32'h22, 3'b000);
    cycle(0, 1, 3'b001, 32'h22, 3'b000);
    check("bp_hold_data1", 64'(ifc.OutputData1), 64'h11);
    cycle(0, 1, 3'b001, 32'h22, 3'b001);
    cycle(0, 0, 3'b000, 32'h0, 3'b001);
    cycle(0, 0, 3'b000, 32'h0, 3'b000);

    // Full-throughput stream on channel 3.
    for (int i = 1; i <= 8; i++) cycle(0, 1, 3'b100, 32'(i), 3'b100);
    cycle(0, 0, 3'b000, 32'h0, 3'b100);

    // Two illegal selects, then saturate the counter.
    cycle(0, 1, 3'b011, 32'h55, 3'b000);
    cycle(0, 1, 3'b000, 32'h55, 3'b000);
    cycle(0, 0, 3'b000, 32'h0, 3'b000);
    check("illegal_cnt2", 64'(ifc.ErrCount), 64'd2);
    for (int i = 0; i < 300; i++)
      cycle(0, 1, illegalSel[$urandom_range(0, 4)], $urandom, 3'($urandom));
    cycle(0, 0, 3'b000, 32'h0, 3'b111);
    check("err_saturated", 64'(ifc.ErrCount), 64'(ERR_MAX));

    // Interleave with channel 2 stalled.
    for (int i = 0; i < 30; i++) begin
      logic [2:0] s;
      s = 3'b001 << (i % 3);
      cycle(0, 1, s, 32'h100 + 32'(i), 3'b101);
    end
    cycle(1, 0, 3'b000, 32'h0, 3'b000);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] s;
      if ($urandom_range(0, 3) != 0) s = 3'b001 << $urandom_range(0, 2);
      else                           s = 3'($urandom_range(0, 7));
      cycle(($urandom_range(0, 127) == 0), $urandom_range(0, 1), s, $urandom,
            3'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
